mul_seq_unit: RTL and testbench
===============================

# mul_seq_unit

Iterative 32x32 shift-add multiplier that sits directly upstream of the register file write port. It accepts one multiply at a time from the control path and runs WIDTH iterations. It then issues a single-cycle write of the low product word to the destination register through the register file's `addrw`/`din`/`wren` inputs. The high product word is held on a separate output for the next instruction.

## Interface
- `WIDTH`, 32, operand width; product is 2*WIDTH.
- `AW`, 5, register address width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op_a`  in  WIDTH  multiplicand, sampled with `start`.
- `op_b`  in  WIDTH  multiplier, sampled with `start`.
- `dest`  in  AW  destination register, sampled with `start`.
- `signed_op`  in  1  two's-complement request; only used with `MUL_SIGNED_EN`.
- `busy`  out  1  high in RUN and WB.
- `done`  out  1  one-cycle pulse in WB.
- `rf_wren`  out  1  register file write enable.
- `rf_addrw`  out  AW  register file write address.
- `rf_din`  out  WIDTH  register file write data: product[WIDTH-1:0].
- `hi`  out  WIDTH  product[2*WIDTH-1:WIDTH]; holds until the next accepted start.

## Operation
- FSM states:
  - IDLE: wait for `start`.
  - RUN: iterate.
  - WB: write back.
- IDLE to RUN on `start`=1:
  - Latch `op_a`, `op_b`, `dest` and the sign mode.
  - Clear the accumulator (2*WIDTH bits).
  - Clear the iteration counter (clog2(WIDTH)+1 bits).
- RUN, each cycle:
  - If multiplier bit 0 is 1, add the multiplicand into the upper half of the accumulator, keeping the carry.
  - Shift the {carry, acc, multiplier} chain right by one.
  - Increment the counter.
- RUN to WB after exactly WIDTH iterations.
- WB, one cycle:
  - `rf_addrw`=dest.
  - `rf_din`=product low word.
  - `hi` updated with product high word.
  - `done`=1.
  - `rf_wren`=1 unless dest==0; writes to register 0 are suppressed and `done` still pulses.
  - WB to IDLE unconditionally.
- `start` while `busy`=1 (RUN or WB): ignored, no queuing, no operand capture.
- Outside WB:
  - `rf_wren`=0 and `done`=0.
  - `rf_addrw` and `rf_din` are driven 0.
- All arithmetic is unsigned modulo 2^(2*WIDTH); there is no overflow flag.

## Timing
- Reset (asserted low, asynchronous): FSM=IDLE and the counter clears.
  - Outputs: `busy`=0, `done`=0, `rf_wren`=0, `rf_addrw`=0, `rf_din`=0, `hi`=0.
- Reset mid-operation: abort; no write is issued; `hi` is cleared.
- Latency: with `start` sampled at edge N, the state is RUN for edges N+1..N+WIDTH.
  - The state is WB in the cycle after edge N+WIDTH, i.e. `rf_wren`/`done` are high WIDTH+1 cycles after `start` (33 for WIDTH=32).
  - The state returns to IDLE at edge N+WIDTH+1.
- Throughput: one multiply per WIDTH+2 cycles. The earliest next `start` is sampled in the first IDLE cycle after WB.
- The register file captures `rf_din` on the same edge that ends WB.
- The control path must stall the pipeline while `busy`=1.

## Configuration
- `MUL_SIGNED_EN` defined:
  - With `signed_op`=1 at start, the operands are converted to magnitudes and the sign (a[MSB]^b[MSB]) is latched.
  - In WB the 2*WIDTH product is two's-complement negated when the sign is 1, before driving `rf_din`/`hi`.
  - The low word is identical to unsigned; `hi` is signed-correct.
- `MUL_SIGNED_EN` undefined:
  - `signed_op` is ignored and all operations are unsigned.
  - No sign/negation logic is synthesized.

## Test plan
- Basic multiply: reset low 2 cycles, release; start a=6, b=7, dest=5.
  - Required: `busy` is high for 33 cycles.
  - Required: `rf_wren`=1, `rf_addrw`=5, `rf_din`=42, `hi`=0 and `done`=1 in cycle 33 only.
- Unsigned maximum: a=b=0xFFFFFFFF, dest=3.
  - Required: `rf_din`=0x00000001, `hi`=0xFFFFFFFE.
- Start while busy: start a=2, b=3, dest=1; 10 cycles later pulse start a=9, b=9, dest=2.
  - Required: a single write, addr 1, data 6.
  - Required: no write to 2.
- Destination zero: start a=4, b=4, dest=0.
  - Required: `done` pulses, `rf_wren` stays 0, `hi`=0.
- Reset mid-operation: start a=5, b=5, dest=7; assert reset at cycle 12.
  - Required: all outputs 0 immediately, `busy`=0.
  - Required: no `rf_wren` in the following 40 cycles.
- Signed (`MUL_SIGNED_EN`): a=0xFFFFFFFD (-3), b=5, `signed_op`=1.
  - Required: `rf_din`=0xFFFFFFF1, `hi`=0xFFFFFFFF.
  - Required without the macro: `hi`=0x00000004.

Source files
------------

// File: rtl/mul_seq_unit.sv
// Iterative shift-add multiplier feeding the register file write port; one low-word write per multiply.
// Optional two's-complement mode is enabled with `define MUL_SIGNED_EN.
module mul_seq_unit #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [AW-1:0]    dest,
    input  logic             signed_op,
    output logic             busy,
    output logic             done,
    output logic             rf_wren,
    output logic [AW-1:0]    rf_addrw,
    output logic [WIDTH-1:0] rf_din,
    output logic [WIDTH-1:0] hi,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [AW-1:0]      dest_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;

`ifdef MUL_SIGNED_EN
    logic sign_in;
    logic sign_q;

    // Signed requests iterate on magnitudes; the sign is reapplied to the full product.
    always_comb begin
        sign_in = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        a_in    = (signed_op && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
        b_in    = (signed_op && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
        prod    = sign_q ? (~acc + 1'b1) : acc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            sign_q <= sign_in;
        end
    end
`else
    logic signed_op_unused;

    assign signed_op_unused = signed_op;
    assign a_in             = op_a;
    assign b_in             = op_b;
    assign prod             = acc;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (cnt == CW'(WIDTH - 1)) state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Carry-keeping add of the multiplicand into the upper accumulator half.
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            dest_q <= '0;
            hi_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a_in;
                        mplier <= b_in;
                        dest_q <= dest;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= {acc[0], mplier[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                end
                S_WB: begin
                    hi_q <= prod[2*WIDTH-1:WIDTH];
                end
                default: ;
            endcase
        end
    end

    // The high word is visible during WB and held in hi_q afterwards.
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_WB);
    assign rf_wren   = done && (dest_q != '0);
    assign rf_addrw  = done ? dest_q : '0;
    assign rf_din    = done ? prod[WIDTH-1:0] : '0;
    assign hi        = done ? prod[2*WIDTH-1:WIDTH] : hi_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Self-checking bench for mul_seq_unit: directed scenarios plus randomized multiplies against a plain-arithmetic model.
// Honours `define MUL_SIGNED_EN the same way as the design.
module tb_mul_seq_unit;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [AW-1:0] dest;
    logic          signed_op;
    logic          busy;
    logic          done;
    logic          rf_wren;
    logic [AW-1:0] rf_addrw;
    logic [W-1:0]  rf_din;
    logic [W-1:0]  hi;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;

    // Expected register file writes, {addr, data}, in issue order.
    logic [AW+W-1:0] exp_q[$];

    mul_seq_unit #(.WIDTH(W), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .dest      (dest),
        .signed_op (signed_op),
        .busy      (busy),
        .done      (done),
        .rf_wren   (rf_wren),
        .rf_addrw  (rf_addrw),
        .rf_din    (rf_din),
        .hi        (hi),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                  input logic s);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`ifdef MUL_SIGNED_EN
        if (s) p = 64'(longint'($signed(a)) * longint'($signed(b)));
`endif
        return p;
    endfunction

    // Write monitor: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_wren === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: addr=%0d data=%h, no write expected", rf_addrw, rf_din);
            end else begin
                logic [AW+W-1:0] e;
                e = exp_q.pop_front();
                if ({rf_addrw, rf_din} !== e) begin
                    failures++;
                    $display("FAIL wr_data: got addr=%0d data=%h, want addr=%0d data=%h",
                             rf_addrw, rf_din, e[AW+W-1:W], e[W-1:0]);
                end
            end
        end
    end

    // Issue one multiply and observe it until done (or a cycle budget expires).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [AW-1:0] d,
                          input logic s, output int busy_n, output int done_at, output int wren_n,
                          output int nz_n, output logic [W-1:0] w_data, output logic [W-1:0] w_hi);
        logic [2*W-1:0] p;
        p = model_prod(a, b, s);
        if (d != 0) exp_q.push_back({d, p[W-1:0]});
        busy_n = 0; done_at = -1; wren_n = 0; nz_n = 0; w_data = '0; w_hi = '0;
        @(negedge clk);
        op_a = a; op_b = b; dest = d; signed_op = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= W + 6; c++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (rf_wren === 1'b1) wren_n++;
            if (done !== 1'b1 && (rf_wren !== 1'b0 || rf_addrw !== '0 || rf_din !== '0)) nz_n++;
            if (done === 1'b1) begin
                done_at = c;
                w_data  = rf_din;
                w_hi    = hi;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op_a = '0; op_b = '0; dest = '0; signed_op = 1'b0;
        repeat (2) @(negedge clk);
        checks += 6;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done); end
        if (rf_wren !== 1'b0) begin failures++; $display("FAIL rst_wren: got %b want 0", rf_wren); end
        if (rf_addrw !== '0) begin failures++; $display("FAIL rst_addrw: got %0d want 0", rf_addrw); end
        if (rf_din !== '0) begin failures++; $display("FAIL rst_din: got %h want 0", rf_din); end
        if (hi !== '0) begin failures++; $display("FAIL rst_hi: got %h want 0", hi); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int bn, da, wn, nz;
        logic [W-1:0] dv, hv;
        run_op(32'd6, 32'd7, 5'd5, 1'b0, bn, da, wn, nz, dv, hv);
        checks += 6;
        if (bn !== 33) begin failures++; $display("FAIL basic_busy_len: got %0d want 33", bn); end
        if (da !== 33) begin failures++; $display("FAIL basic_done_cycle: got %0d want 33", da); end
        if (wn !== 1) begin failures++; $display("FAIL basic_wren_cnt: got %0d want 1", wn); end
        if (nz !== 0) begin failures++; $display("FAIL basic_idle_outputs: got %0d want 0 nonzero cycles", nz); end
        if (dv !== 32'd42) begin failures++; $display("FAIL basic_din: got %h want 2a", dv); end
        if (hv !== 32'd0) begin failures++; $display("FAIL basic_hi: got %h want 0", hv); end
        @(negedge clk);
        checks += 2;
        if (done !== 1'b0) begin failures++; $display("FAIL basic_done_width: got %b want 0", done); end
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_unsigned_max();
        int bn, da, wn, nz;
        logic [W-1:0] dv, hv;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, bn, da, wn, nz, dv, hv);
        checks += 3;
        if (da !== 33) begin failures++; $display("FAIL max_done_cycle: got %0d want 33", da); end
        if (dv !== 32'h0000_0001) begin failures++; $display("FAIL max_din: got %h want 00000001", dv); end
        if (hv !== 32'hFFFF_FFFE) begin failures++; $display("FAIL max_hi: got %h want fffffffe", hv); end
    endtask

    task automatic test_reset_mid();
        int wn;
        @(negedge clk);
        op_a = 32'd5; op_b = 32'd5; dest = 5'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(negedge clk);
        reset = 1'b0;
        #1;
        checks += 6;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b want 0", done); end
        if (rf_wren !== 1'b0) begin failures++; $display("FAIL midrst_wren: got %b want 0", rf_wren); end
        if (rf_addrw !== '0) begin failures++; $display("FAIL midrst_addrw: got %0d want 0", rf_addrw); end
        if (rf_din !== '0) begin failures++; $display("FAIL midrst_din: got %h want 0", rf_din); end
        if (hi !== '0) begin failures++; $display("FAIL midrst_hi: got %h want 0", hi); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rf_wren !== 1'b0) wn++;
        end
        checks++;
        if (wn !== 0) begin failures++; $display("FAIL midrst_no_write: got %0d writes want 0", wn); end
    endtask

    task automatic test_start_while_busy();
        int wn, w2, dn, da;
        logic [W-1:0] dv;
        wn = 0; w2 = 0; dn = 0; da = -1; dv = '0;
        exp_q.push_back({5'd1, 32'd6});
        @(negedge clk);
        op_a = 32'd2; op_b = 32'd3; dest = 5'd1; signed_op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (rf_wren === 1'b1) begin
                wn++;
                if (rf_addrw === 5'd2) w2++;
                dv = rf_din;
            end
            if (done === 1'b1) begin dn++; da = c; end
            if (c == 10) begin
                op_a = 32'd9; op_b = 32'd9; dest = 5'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks += 5;
        if (wn !== 1) begin failures++; $display("FAIL swb_write_cnt: got %0d want 1", wn); end
        if (w2 !== 0) begin failures++; $display("FAIL swb_write_r2: got %0d want 0", w2); end
        if (dv !== 32'd6) begin failures++; $display("FAIL swb_data: got %h want 6", dv); end
        if (dn !== 1) begin failures++; $display("FAIL swb_done_cnt: got %0d want 1", dn); end
        if (da !== 33) begin failures++; $display("FAIL swb_done_cycle: got %0d want 33", da); end
    endtask

    task automatic test_dest_zero();
        int bn, da, wn, nz;
        logic [W-1:0] dv, hv;
        run_op(32'd4, 32'd4, 5'd0, 1'b0, bn, da, wn, nz, dv, hv);
        checks += 4;
        if (da !== 33) begin failures++; $display("FAIL dz_done: got cycle %0d want 33", da); end
        if (wn !== 0) begin failures++; $display("FAIL dz_wren: got %0d writes want 0", wn); end
        if (dv !== 32'd16) begin failures++; $display("FAIL dz_din: got %h want 10", dv); end
        if (hv !== 32'd0) begin failures++; $display("FAIL dz_hi: got %h want 0", hv); end
    endtask

    task automatic test_signed();
        int bn, da, wn, nz;
        logic [W-1:0] dv, hv, exp_hi;
`ifdef MUL_SIGNED_EN
        exp_hi = 32'hFFFF_FFFF;
`else
        exp_hi = 32'h0000_0004;
`endif
        run_op(32'hFFFF_FFFD, 32'd5, 5'd9, 1'b1, bn, da, wn, nz, dv, hv);
        checks += 2;
        if (dv !== 32'hFFFF_FFF1) begin failures++; $display("FAIL signed_din: got %h want fffffff1", dv); end
        if (hv !== exp_hi) begin failures++; $display("FAIL signed_hi: got %h want %h", hv, exp_hi); end
        repeat (3) @(negedge clk);
        checks++;
        if (hi !== exp_hi) begin failures++; $display("FAIL signed_hi_hold: got %h want %h", hi, exp_hi); end
    endtask

    task automatic test_random();
        int bn, da, wn, nz;
        logic [W-1:0] a, b, dv, hv;
        logic [AW-1:0] d;
        logic s;
        logic [2*W-1:0] p;
        for (int i = 0; i < 12; i++) begin
            a = $urandom();
            b = $urandom();
            if (i == 0) a = 32'h8000_0000;
            if (i == 1) b = 32'h0;
            if (i == 2) begin a = 32'h7FFF_FFFF; b = 32'h8000_0000; end
            d = 5'($urandom_range(0, 31));
            s = 1'($urandom_range(0, 1));
            p = model_prod(a, b, s);
            run_op(a, b, d, s, bn, da, wn, nz, dv, hv);
            checks += 4;
            if (da !== 33) begin failures++; $display("FAIL rnd%0d_done_cycle: got %0d want 33", i, da); end
            if (dv !== p[W-1:0]) begin failures++; $display("FAIL rnd%0d_din: a=%h b=%h s=%b got %h want %h", i, a, b, s, dv, p[W-1:0]); end
            if (hv !== p[2*W-1:W]) begin failures++; $display("FAIL rnd%0d_hi: a=%h b=%h s=%b got %h want %h", i, a, b, s, hv, p[2*W-1:W]); end
            if (wn !== ((d != 0) ? 1 : 0)) begin failures++; $display("FAIL rnd%0d_wren_cnt: got %0d dest=%0d", i, wn, d); end
        end
    endtask

    task automatic test_back_to_back();
        int bn, da, wn, nz;
        logic [W-1:0] dv, hv;
        logic [2*W-1:0] p;
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] a, b;
            a = $urandom();
            b = $urandom();
            p = model_prod(a, b, 1'b0);
            run_op(a, b, 5'(i + 10), 1'b0, bn, da, wn, nz, dv, hv);
            checks += 3;
            if (da !== 33) begin failures++; $display("FAIL b2b%0d_done_cycle: got %0d want 33", i, da); end
            if (dv !== p[W-1:0]) begin failures++; $display("FAIL b2b%0d_din: got %h want %h", i, dv, p[W-1:0]); end
            if (hv !== p[2*W-1:W]) begin failures++; $display("FAIL b2b%0d_hi: got %h want %h", i, hv, p[2*W-1:W]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unsigned_max();
        test_reset_mid();
        test_start_while_busy();
        test_dest_zero();
        test_signed();
        test_random();
        test_back_to_back();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
